// File: rtl/updown_push_ctrl.sv
// Button front-end for the up/down counter: sync, debounce, arbitrate, strobe.
// Optional hold-to-repeat is built only when UPDOWN_AUTO_REPEAT_EN is defined.
module updown_push_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push1,
    input  logic push2,
    output logic cmd_up,
    output logic cmd_dn,
    output logic lock
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HOLD_UP = 3'd1;
    localparam logic [2:0] HOLD_DN = 3'd2;
    localparam logic [2:0] LOCK    = 3'd5;
`ifdef UPDOWN_AUTO_REPEAT_EN
    localparam logic [2:0] RPT_UP  = 3'd3;
    localparam logic [2:0] RPT_DN  = 3'd4;
    localparam logic [7:0] DELAY_LAST = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] RATE_LAST  = 8'(REPEAT_RATE - 1);
`endif
    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..255");
    end
    if (REPEAT_DELAY < 2 || REPEAT_DELAY > 255) begin : g_bad_delay
        $error("REPEAT_DELAY out of range 2..255");
    end
    if (REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_rate
        $error("REPEAT_RATE out of range 1..255");
    end

    logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [7:0] db1_cnt_q, db1_cnt_d, db2_cnt_q, db2_cnt_d;
    logic       d1_q, d1_d, d2_q, d2_d;
    logic [2:0] state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       cmd_up_q, cmd_up_d, cmd_dn_q, cmd_dn_d, lock_q, lock_d;

    always_comb begin
        sync1_d = {sync1_q[0], push1};
        sync2_d = {sync2_q[0], push2};

        // The debounced level flips on the cycle after the counter has
        // recorded DEBOUNCE_CYCLES consecutive disagreeing samples.
        d1_d      = d1_q;
        db1_cnt_d = 8'd0;
        if (sync1_q[1] != d1_q) begin
            if (db1_cnt_q == DB_LIMIT) d1_d = ~d1_q;
            else                       db1_cnt_d = db1_cnt_q + 8'd1;
        end

        d2_d      = d2_q;
        db2_cnt_d = 8'd0;
        if (sync2_q[1] != d2_q) begin
            if (db2_cnt_q == DB_LIMIT) d2_d = ~d2_q;
            else                       db2_cnt_d = db2_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_up_d   = 1'b0;
        cmd_dn_d   = 1'b0;
        hold_cnt_d = (hold_cnt_q == 8'hff) ? hold_cnt_q : hold_cnt_q + 8'd1;

        // IDLE is only ever entered with both levels low, so a high level here is a rise.
        case (state_q)
            IDLE: begin
                if (d1_q && d2_q) begin
                    state_d = LOCK;
                end else if (d1_q) begin
                    state_d  = HOLD_UP;
                    cmd_up_d = 1'b1;
                end else if (d2_q) begin
                    state_d  = HOLD_DN;
                    cmd_dn_d = 1'b1;
                end
            end
            HOLD_UP: begin
                if (d2_q) state_d = LOCK;
                else if (!d1_q) state_d = IDLE;
`ifdef UPDOWN_AUTO_REPEAT_EN
                else if (hold_cnt_q == DELAY_LAST) begin
                    state_d  = RPT_UP;
                    cmd_up_d = 1'b1;
                end
`endif
            end
            HOLD_DN: begin
                if (d1_q) state_d = LOCK;
                else if (!d2_q) state_d = IDLE;
`ifdef UPDOWN_AUTO_REPEAT_EN
                else if (hold_cnt_q == DELAY_LAST) begin
                    state_d  = RPT_DN;
                    cmd_dn_d = 1'b1;
                end
`endif
            end
`ifdef UPDOWN_AUTO_REPEAT_EN
            RPT_UP: begin
                if (d2_q) state_d = LOCK;
                else if (!d1_q) state_d = IDLE;
                else if (hold_cnt_q == RATE_LAST) begin
                    cmd_up_d   = 1'b1;
                    hold_cnt_d = 8'd0;
                end
            end
            RPT_DN: begin
                if (d1_q) state_d = LOCK;
                else if (!d2_q) state_d = IDLE;
                else if (hold_cnt_q == RATE_LAST) begin
                    cmd_dn_d   = 1'b1;
                    hold_cnt_d = 8'd0;
                end
            end
`endif
            LOCK: begin
                if (!d1_q && !d2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) hold_cnt_d = 8'd0;
        lock_d = (state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            db1_cnt_q  <= 8'd0;
            db2_cnt_q  <= 8'd0;
            d1_q       <= 1'b0;
            d2_q       <= 1'b0;
            state_q    <= IDLE;
            hold_cnt_q <= 8'd0;
            cmd_up_q   <= 1'b0;
            cmd_dn_q   <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db1_cnt_q  <= db1_cnt_d;
            db2_cnt_q  <= db2_cnt_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cmd_up_q   <= cmd_up_d;
            cmd_dn_q   <= cmd_dn_d;
            lock_q     <= lock_d;
        end
    end

    assign cmd_up = cmd_up_q;
    assign cmd_dn = cmd_dn_q;
    assign lock   = lock_q;

endmodule

// File: tb/tb_updown_push_ctrl.sv
// Directed bench for updown_push_ctrl; cycle index i counts posedges from the
// first edge that samples the new input level (edge 0), outputs read 1ns after.
module tb_updown_push_ctrl;

`ifdef UPDOWN_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic push1 = 1'b0;
    logic push2 = 1'b0;
    logic cmd_up, cmd_dn, lock;
    int   pass_cnt = 0;
    int   check_cnt = 0;

    always #5 clk = ~clk;

    updown_push_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .push1  (push1),
        .push2  (push2),
        .cmd_up (cmd_up),
        .cmd_dn (cmd_dn),
        .lock   (lock)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        push1 = 1'b0;
        push2 = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check_cnt++;
        if (cmd_up !== 1'b0) $display("FAIL reset_cmd_up got %b exp 0", cmd_up);
        else pass_cnt++;
        check_cnt++;
        if (cmd_dn !== 1'b0) $display("FAIL reset_cmd_dn got %b exp 0", cmd_dn);
        else pass_cnt++;
        check_cnt++;
        if (lock !== 1'b0) $display("FAIL reset_lock got %b exp 0", lock);
        else pass_cnt++;
        rst = 1'b0;
        settle(5);
    endtask

    task automatic test_clean_press();
        logic eu;
        push1 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            eu = (i == 7) || (AR && (i == 15 || i == 19 || i == 23));
            check_cnt++;
            if ({cmd_up, cmd_dn, lock} !== {eu, 1'b0, 1'b0})
                $display("FAIL clean_press t=%0d up/dn/lock got %b%b%b exp %b00",
                         i, cmd_up, cmd_dn, lock, eu);
            else pass_cnt++;
            if (i == 19) push1 = 1'b0;
        end
        settle(10);
    endtask

    task automatic test_glitch();
        push2 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check_cnt++;
            if ({cmd_up, cmd_dn, lock} !== 3'b000)
                $display("FAIL glitch t=%0d up/dn/lock got %b%b%b exp 000",
                         i, cmd_up, cmd_dn, lock);
            else pass_cnt++;
            push2 = ((i + 1) < 15) && (((i + 1) % 5) < 3);
        end
        settle(10);
    endtask

    task automatic test_auto_repeat();
        logic eu;
        push1 = 1'b1;
        for (int i = 0; i < 56; i++) begin
            tick();
            // Repeat due at 47 coincides with the debounced release and must be dropped.
            eu = (i == 7) || (AR && i >= 15 && i <= 43 && ((i - 15) % 4) == 0);
            check_cnt++;
            if ({cmd_up, cmd_dn, lock} !== {eu, 1'b0, 1'b0})
                $display("FAIL auto_repeat t=%0d up/dn/lock got %b%b%b exp %b00",
                         i, cmd_up, cmd_dn, lock, eu);
            else pass_cnt++;
            if (i == 39) push1 = 1'b0;
        end
        settle(10);
    endtask

    task automatic test_simultaneous();
        logic el;
        push1 = 1'b1;
        push2 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            el = (i >= 7) && (i < 42);
            check_cnt++;
            if ({cmd_up, cmd_dn, lock} !== {1'b0, 1'b0, el})
                $display("FAIL simultaneous t=%0d up/dn/lock got %b%b%b exp 00%b",
                         i, cmd_up, cmd_dn, lock, el);
            else pass_cnt++;
            if (i == 19) push1 = 1'b0;
            if (i == 34) push2 = 1'b0;
        end
        settle(10);
    endtask

    task automatic test_overlap();
        logic eu, ed, el;
        push2 = 1'b1;
        for (int i = 0; i < 66; i++) begin
            tick();
            eu = (i == 48) || (AR && i == 56);
            ed = (i == 7) || (AR && i == 15);
            el = (i >= 17) && (i < 32);
            check_cnt++;
            if ({cmd_up, cmd_dn, lock} !== {eu, ed, el})
                $display("FAIL overlap t=%0d up/dn/lock got %b%b%b exp %b%b%b",
                         i, cmd_up, cmd_dn, lock, eu, ed, el);
            else pass_cnt++;
            if (i == 9) push1 = 1'b1;
            if (i == 24) begin
                push1 = 1'b0;
                push2 = 1'b0;
            end
            if (i == 40) push1 = 1'b1;
            if (i == 52) push1 = 1'b0;
        end
        settle(10);
    endtask

    task automatic test_reset_mid_hold();
        logic eu;
        push1 = 1'b1;
        for (int i = 0; i < 31; i++) begin
            tick();
            eu = (i == 7) || (i == 20) || (AR && i == 28);
            check_cnt++;
            if ({cmd_up, cmd_dn, lock} !== {eu, 1'b0, 1'b0})
                $display("FAIL reset_mid_hold t=%0d up/dn/lock got %b%b%b exp %b00",
                         i, cmd_up, cmd_dn, lock, eu);
            else pass_cnt++;
            if (i == 11) rst = 1'b1;
            if (i == 12) rst = 1'b0;
        end
        settle(15);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_auto_repeat();
        test_simultaneous();
        test_overlap();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
